// File: rtl/xbar_pkg.sv
// Shared definitions for the 2x2 crossbar: status codes seen by the
// rdata router, arbiter state encoding and command values.
package xbar_pkg;

    localparam logic [1:0] NO_REQ = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] W_ACK  = 2'd2;
    localparam logic [1:0] W_DATA = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDATA = 2'd2
    } fsm_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    function automatic logic [1:0] idle_stat(input logic v);
        return v ? WAIT : NO_REQ;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the master not served last wins.
module rr_pick2 (
    input  logic v0,
    input  logic v1,
    input  logic last,
    output logic any,
    output logic winner
);

    assign any    = v0 | v1;
    assign winner = (v0 & v1) ? ~last : v1;

endmodule

// File: rtl/slave_port_arbiter.sv
// Per-slave round-robin arbiter for the 2-master / 2-slave crossbar.
// Forwards the granted request, routes the ack and publishes status.
module slave_port_arbiter
    import xbar_pkg::*;
#(
    parameter logic S_NO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_cmd,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_cmd,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        s_req,
    output logic [31:0] s_addr,
    output logic        s_cmd,
    output logic [31:0] s_wdata,
    input  logic        s_ack,
    output logic [1:0]  stat0,
    output logic [1:0]  stat1,
    output logic        slave0,
    output logic        slave1
);

    fsm_e r_fsm;
    fsm_e w_fsm_nxt;
    logic r_grant;
    logic w_grant_nxt;
    logic r_last;
    logic w_last_nxt;
    logic w_v0;
    logic w_v1;
    logic w_any;
    logic w_win;
    logic w_gv;
    logic w_gcmd;

    assign w_v0   = m0_req & (m0_addr[31] == S_NO);
    assign w_v1   = m1_req & (m1_addr[31] == S_NO);
    assign slave0 = m0_addr[31];
    assign slave1 = m1_addr[31];

    assign w_gv   = r_grant ? w_v1 : w_v0;
    assign w_gcmd = r_grant ? m1_cmd : m0_cmd;

    rr_pick2 u_pick (
        .v0     (w_v0),
        .v1     (w_v1),
        .last   (r_last),
        .any    (w_any),
        .winner (w_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        s_req       = 1'b0;
        s_addr      = '0;
        s_cmd       = 1'b0;
        s_wdata     = '0;
        m0_ack      = 1'b0;
        m1_ack      = 1'b0;
        stat0       = idle_stat(w_v0);
        stat1       = idle_stat(w_v1);
        unique case (r_fsm)
            IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_win;
                    w_fsm_nxt   = REQ;
                end
            end
            REQ: begin
                s_req   = 1'b1;
                s_addr  = r_grant ? m1_addr : m0_addr;
                s_cmd   = w_gcmd;
                s_wdata = r_grant ? m1_wdata : m0_wdata;
                if (r_grant) stat1 = W_ACK;
                else         stat0 = W_ACK;
                // a master withdrawing before the ack forfeits its turn
                if (!w_gv) begin
                    w_fsm_nxt = IDLE;
                end else if (s_ack) begin
                    m0_ack     = ~r_grant;
                    m1_ack     = r_grant;
                    w_last_nxt = r_grant;
                    w_fsm_nxt  = (w_gcmd == CMD_READ) ? RDATA : IDLE;
                end
            end
            RDATA: begin
                if (r_grant) stat1 = W_DATA;
                else         stat0 = W_DATA;
                w_fsm_nxt = IDLE;
            end
            default: begin
                w_fsm_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Bench: both slave-port instances of the crossbar against a
// transaction-level model, plus directed literal checks.
module tb_slave_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0;
    logic        m1_req = 1'b0;
    logic [31:0] m0_addr = '0;
    logic [31:0] m1_addr = '0;
    logic        m0_cmd = 1'b0;
    logic        m1_cmd = 1'b0;
    logic [31:0] m0_wdata = '0;
    logic [31:0] m1_wdata = '0;
    logic [1:0]  sack = 2'b00;

    logic        o_ack0  [2];
    logic        o_ack1  [2];
    logic        o_sreq  [2];
    logic [31:0] o_saddr [2];
    logic        o_scmd  [2];
    logic [31:0] o_swd   [2];
    logic [1:0]  o_st0   [2];
    logic [1:0]  o_st1   [2];
    logic        o_sl0   [2];
    logic        o_sl1   [2];

    int n_pass = 0;
    int n_total = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    slave_port_arbiter #(.S_NO(1'b0)) u0 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_cmd(m0_cmd),
        .m0_wdata(m0_wdata), .m0_ack(o_ack0[0]),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_cmd(m1_cmd),
        .m1_wdata(m1_wdata), .m1_ack(o_ack1[0]),
        .s_req(o_sreq[0]), .s_addr(o_saddr[0]), .s_cmd(o_scmd[0]),
        .s_wdata(o_swd[0]), .s_ack(sack[0]),
        .stat0(o_st0[0]), .stat1(o_st1[0]),
        .slave0(o_sl0[0]), .slave1(o_sl1[0])
    );

    slave_port_arbiter #(.S_NO(1'b1)) u1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_cmd(m0_cmd),
        .m0_wdata(m0_wdata), .m0_ack(o_ack0[1]),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_cmd(m1_cmd),
        .m1_wdata(m1_wdata), .m1_ack(o_ack1[1]),
        .s_req(o_sreq[1]), .s_addr(o_saddr[1]), .s_cmd(o_scmd[1]),
        .s_wdata(o_swd[1]), .s_ack(sack[1]),
        .stat0(o_st0[1]), .stat1(o_st1[1]),
        .slave0(o_sl0[1]), .slave1(o_sl1[1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // model: owner of each slave port (-1 free), data-cycle flag, last served
    int own [2] = '{-1, -1};
    bit rd  [2] = '{1'b0, 1'b0};
    int lst [2] = '{1, 1};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [31:0] ma [2];
            logic        mc [2];
            logic [31:0] mw [2];
            bit          mv [2];
            bit          e_sreq;
            logic [31:0] e_addr;
            logic        e_cmd;
            logic [31:0] e_wd;
            bit          e_ack [2];
            logic [1:0]  e_st [2];
            int          o;
            ma[0] = m0_addr; ma[1] = m1_addr;
            mc[0] = m0_cmd;  mc[1] = m1_cmd;
            mw[0] = m0_wdata; mw[1] = m1_wdata;
            mv[0] = m0_req && (m0_addr[31] == (k == 1));
            mv[1] = m1_req && (m1_addr[31] == (k == 1));
            o = own[k];
            e_sreq = 1'b0; e_addr = '0; e_cmd = 1'b0; e_wd = '0;
            e_ack[0] = 1'b0; e_ack[1] = 1'b0;
            e_st[0] = mv[0] ? 2'd1 : 2'd0;
            e_st[1] = mv[1] ? 2'd1 : 2'd0;
            if (o >= 0 && !rd[k]) begin
                e_sreq = 1'b1;
                e_addr = ma[o];
                e_cmd  = mc[o];
                e_wd   = mw[o];
                e_st[o] = 2'd2;
                e_ack[o] = sack[k] && mv[o];
            end else if (o >= 0) begin
                e_st[o] = 2'd3;
            end
            if (armed) begin
                chk($sformatf("u%0d.s_req", k), 32'(o_sreq[k]), 32'(e_sreq));
                chk($sformatf("u%0d.s_addr", k), o_saddr[k], e_addr);
                chk($sformatf("u%0d.s_cmd", k), 32'(o_scmd[k]), 32'(e_cmd));
                chk($sformatf("u%0d.s_wdata", k), o_swd[k], e_wd);
                chk($sformatf("u%0d.m0_ack", k), 32'(o_ack0[k]), 32'(e_ack[0]));
                chk($sformatf("u%0d.m1_ack", k), 32'(o_ack1[k]), 32'(e_ack[1]));
                chk($sformatf("u%0d.stat0", k), 32'(o_st0[k]), 32'(e_st[0]));
                chk($sformatf("u%0d.stat1", k), 32'(o_st1[k]), 32'(e_st[1]));
                chk($sformatf("u%0d.slave0", k), 32'(o_sl0[k]), 32'(m0_addr[31]));
                chk($sformatf("u%0d.slave1", k), 32'(o_sl1[k]), 32'(m1_addr[31]));
            end
            if (rst) begin
                own[k] = -1; rd[k] = 1'b0; lst[k] = 1;
            end else if (o < 0) begin
                if (mv[0] && mv[1]) own[k] = 1 - lst[k];
                else if (mv[0])     own[k] = 0;
                else if (mv[1])     own[k] = 1;
            end else if (rd[k]) begin
                own[k] = -1; rd[k] = 1'b0;
            end else if (!mv[o]) begin
                own[k] = -1;
            end else if (sack[k]) begin
                lst[k] = o;
                if (mc[o]) own[k] = -1;
                else       rd[k] = 1'b1;
            end
        end
        if (rst) armed = 1'b1;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic obs;
        @(negedge clk);
    endtask

    initial begin
        step; step;
        rst = 1'b0;
        obs;
        chk("rst s_req", 32'(o_sreq[0]), 32'd0);
        chk("rst s_addr", o_saddr[0], 32'd0);
        chk("rst stat0", 32'(o_st0[0]), 32'd0);
        chk("rst stat1", 32'(o_st1[0]), 32'd0);
        chk("rst m0_ack", 32'(o_ack0[0]), 32'd0);

        // single read, one wait cycle
        step; m0_req = 1; m0_addr = 32'h10; m0_cmd = 0;
        obs; chk("rd wait stat0", 32'(o_st0[0]), 32'd1);
        step;
        obs; chk("rd s_req", 32'(o_sreq[0]), 32'd1);
        chk("rd s_addr", o_saddr[0], 32'h10);
        chk("rd wack stat0", 32'(o_st0[0]), 32'd2);
        chk("rd early ack", 32'(o_ack0[0]), 32'd0);
        step; sack[0] = 1;
        obs; chk("rd m0_ack", 32'(o_ack0[0]), 32'd1);
        chk("rd m1_ack", 32'(o_ack1[0]), 32'd0);
        step; sack[0] = 0; m0_req = 0;
        obs; chk("rd wdata stat0", 32'(o_st0[0]), 32'd3);
        chk("rd data s_req", 32'(o_sreq[0]), 32'd0);
        step;
        obs; chk("rd done stat0", 32'(o_st0[0]), 32'd0);

        // contention: alternate grants 0,1,0
        step; rst = 1;
        step; rst = 0;
        m0_req = 1; m1_req = 1; m0_addr = 0; m1_addr = 0;
        m0_cmd = 0; m1_cmd = 0;
        obs; chk("tie wait0", 32'(o_st0[0]), 32'd1);
        chk("tie wait1", 32'(o_st1[0]), 32'd1);
        for (int t = 0; t < 3; t++) begin
            step; sack[0] = 1;
            obs;
            chk($sformatf("tie%0d ack0", t), 32'(o_ack0[0]), 32'(t % 2 == 0));
            chk($sformatf("tie%0d ack1", t), 32'(o_ack1[0]), 32'(t % 2 == 1));
            step; sack[0] = 0;
            if (t == 2) begin m0_req = 0; m1_req = 0; end
            obs;
            if (t % 2 == 0) chk("tie data0", 32'(o_st0[0]), 32'd3);
            else            chk("tie data1", 32'(o_st1[0]), 32'd3);
            step;
            obs;
        end

        // write on slave 1, zero-wait
        step; m1_req = 1; m1_addr = 32'h8000_0004; m1_cmd = 1;
        m1_wdata = 32'hDEAD_BEEF;
        obs; chk("wr u0 slave1", 32'(o_sl1[0]), 32'd1);
        chk("wr u0 stat1", 32'(o_st1[0]), 32'd0);
        step; sack[1] = 1;
        obs; chk("wr s_wdata", o_swd[1], 32'hDEAD_BEEF);
        chk("wr s_cmd", 32'(o_scmd[1]), 32'd1);
        chk("wr m1_ack", 32'(o_ack1[1]), 32'd1);
        chk("wr stat1", 32'(o_st1[1]), 32'd2);
        step; sack[1] = 0; m1_req = 0;
        obs; chk("wr done stat1", 32'(o_st1[1]), 32'd0);
        chk("wr done s_req", 32'(o_sreq[1]), 32'd0);

        // address filtering on slave 0
        step; m0_req = 1; m0_addr = 32'h8000_0000; m0_cmd = 0;
        obs; chk("flt slave0", 32'(o_sl0[0]), 32'd1);
        chk("flt stat0", 32'(o_st0[0]), 32'd0);
        step;
        obs; chk("flt s_req", 32'(o_sreq[0]), 32'd0);
        step; m0_req = 0;
        obs;
        step;
        obs;

        // reset during the data cycle
        step; m0_req = 1; m0_addr = 0; m0_cmd = 0;
        obs;
        step; sack[0] = 1;
        obs; chk("mr ack0", 32'(o_ack0[0]), 32'd1);
        step; sack[0] = 0; m0_req = 0; rst = 1;
        obs; chk("mr data stat0", 32'(o_st0[0]), 32'd3);
        step; rst = 0;
        obs; chk("mr stat0", 32'(o_st0[0]), 32'd0);
        chk("mr s_req", 32'(o_sreq[0]), 32'd0);
        step; m0_req = 1; m1_req = 1; m1_addr = 0; m1_cmd = 0;
        obs;
        step; sack[0] = 1;
        obs; chk("mr tie ack0", 32'(o_ack0[0]), 32'd1);
        chk("mr tie ack1", 32'(o_ack1[0]), 32'd0);
        step; sack[0] = 0; m0_req = 0; m1_req = 0;
        obs;
        step;
        obs;

        // m1 withdraws before the ack
        step; m1_req = 1;
        obs;
        step;
        obs; chk("drop wack1", 32'(o_st1[0]), 32'd2);
        step; m1_req = 0; sack[0] = 1;
        obs; chk("drop ack1", 32'(o_ack1[0]), 32'd0);
        chk("drop ack0", 32'(o_ack0[0]), 32'd0);
        step; sack[0] = 0; m0_req = 1; m1_req = 1;
        obs; chk("drop idle s_req", 32'(o_sreq[0]), 32'd0);
        step;
        obs; chk("drop tie stat1", 32'(o_st1[0]), 32'd2);
        chk("drop tie stat0", 32'(o_st0[0]), 32'd1);
        step; sack[0] = 1;
        obs; chk("drop tie ack1", 32'(o_ack1[0]), 32'd1);
        step; sack[0] = 0; m0_req = 0; m1_req = 0;
        obs;
        step;
        obs;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
